// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller.
// Holds the frame geometry, the write flag carried in the frame MSB, the
// peripheral register map, the controller state type and a helper that
// converts a phase length in clk cycles into a phase-timer load value.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam logic SPI_WRITE_BIT = 1'b1;

  // Peripheral register map
  localparam logic [6:0] EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // The timer flags terminal count while holding zero, so a phase of N
  // cycles is loaded with N-1.
  function automatic logic [7:0] phase_load(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/status bundle between a bus master and the SPI controller.
//   req_valid / req_ready : write request handshake
//   req_addr  [6:0]       : target register address
//   req_data  [7:0]       : write data
//   busy                  : a frame is in progress
//   done                  : one-cycle pulse when a frame completes
interface spi_controller_if;

  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, busy, done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, busy, done
  );

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable 8-bit down-counter used to time every controller phase.
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : load load_value this cycle (takes priority)
//   load_value  : cycles remaining minus one
//   tc          : terminal count, high while the counter holds zero
// The counter stops at zero instead of wrapping.
module spi_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       tc
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tc = (count == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller. Each accepted request is sent as one
// 16-bit frame {write flag, addr[6:0], data[7:0]}, MSB first, framed by
// ncs with programmable setup, hold and inter-frame gap times.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request handshake and busy/done status (slave side)
//   sclk       : SPI clock, idles low
//   ncs        : chip select, active low
//   copi       : serial data out
// sclk, ncs and copi come straight from flops.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 8,
  parameter int CS_HOLD  = 8,
  parameter int CS_GAP   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  bus,
  output logic             sclk,
  output logic             ncs,
  output logic             copi
);

  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be in 4..255");
  end
  if (CS_SETUP < 1 || CS_SETUP > 255) begin : g_bad_cs_setup
    $error("spi_controller: CS_SETUP must be in 1..255");
  end
  if (CS_HOLD < 1 || CS_HOLD > 255) begin : g_bad_cs_hold
    $error("spi_controller: CS_HOLD must be in 1..255");
  end
  if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_cs_gap
    $error("spi_controller: CS_GAP must be in 1..255");
  end

  spi_state_t                state, state_next;
  logic [SPI_FRAME_BITS-1:0] shreg, shreg_next;
  logic [4:0]                bit_cnt, bit_cnt_next;
  logic                      sclk_next, ncs_next, done_q, done_next;
  logic                      ready_q, ready_next;
  logic                      tmr_load, tmr_tc;
  logic [7:0]                tmr_value;

  spi_phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tc         (tmr_tc)
  );

  // copi is the shift register MSB; zeros shift in behind the frame so
  // the line returns low once the last bit has been sent.
  assign copi          = shreg[SPI_FRAME_BITS-1];
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.req_ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= 5'd0;
      sclk    <= 1'b0;
      ncs     <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      sclk    <= sclk_next;
      ncs     <= ncs_next;
      done_q  <= done_next;
      ready_q <= ready_next;
    end
  end

  // Next state plus next values of every registered output. Each phase
  // change reloads the timer with the length of the phase being entered.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    sclk_next    = sclk;
    ncs_next     = ncs;
    done_next    = 1'b0;
    tmr_load     = 1'b0;
    tmr_value    = 8'd0;

    case (state)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          state_next   = ST_SETUP;
          shreg_next   = {SPI_WRITE_BIT, bus.req_addr, bus.req_data};
          bit_cnt_next = 5'd0;
          ncs_next     = 1'b0;
          sclk_next    = 1'b0;
          tmr_load     = 1'b1;
          tmr_value    = phase_load(CS_SETUP);
        end
      end

      ST_SETUP: begin
        if (tmr_tc) begin
          state_next = ST_SHIFT;
          tmr_load   = 1'b1;
          tmr_value  = phase_load(CLK_DIV);
        end
      end

      ST_SHIFT: begin
        if (tmr_tc) begin
          tmr_load  = 1'b1;
          tmr_value = phase_load(CLK_DIV);
          if (!sclk) begin
            sclk_next = 1'b1;
          end else begin
            // End of a high phase: sclk falls and the next bit is presented.
            sclk_next    = 1'b0;
            shreg_next   = {shreg[SPI_FRAME_BITS-2:0], 1'b0};
            bit_cnt_next = bit_cnt + 5'd1;
            if (bit_cnt == 5'(SPI_FRAME_BITS - 1)) begin
              state_next = ST_HOLD;
              tmr_value  = phase_load(CS_HOLD);
            end
          end
        end
      end

      ST_HOLD: begin
        if (tmr_tc) begin
          state_next = ST_GAP;
          ncs_next   = 1'b1;
          done_next  = 1'b1;
          tmr_load   = 1'b1;
          tmr_value  = phase_load(CS_GAP);
        end
      end

      ST_GAP: begin
        if (tmr_tc) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        ncs_next   = 1'b1;
        sclk_next  = 1'b0;
      end
    endcase

    // Registered so that req_ready stays low during reset and rises on
    // the first edge after release.
    ready_next = (state_next == ST_IDLE);
  end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller with default timing parameters.
// A cycle-offset model predicts every output each cycle from the frame
// timing rules; a bus monitor acts as the peripheral, decoding frames into
// a small register file and measuring edge-to-edge timing.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int CLK_DIV   = 8;
  localparam int CS_SETUP  = 8;
  localparam int CS_HOLD   = 8;
  localparam int CS_GAP    = 16;
  localparam int SHIFT_END = CS_SETUP + 2 * SPI_FRAME_BITS * CLK_DIV;
  localparam int LOW_LEN   = SHIFT_END + CS_HOLD;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, ncs, copi;

  spi_controller_if bus();

  spi_controller #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .CS_GAP   (CS_GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sclk  (sclk),
    .ncs   (ncs),
    .copi  (copi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_min(input string name, input int act, input int min_val);
    total++;
    if (act < min_val) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required>=%0d", name, act, min_val);
    end
  endtask

  // Model: acceptance cycle and latched frame; everything else follows
  // from the cycle offset since acceptance.
  int          acc_cyc = -1;
  logic [15:0] m_frame = 16'h0;
  bit          m_rdy;

  function automatic bit m_ready(input int c);
    if (acc_cyc < 0) return (c >= 1);
    return ((c - acc_cyc) >= LOW_LEN + CS_GAP);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc     = 0;
      acc_cyc = -1;
    end else begin
      m_rdy = m_ready(cyc);
      cyc   = cyc + 1;
      if (m_rdy && bus.req_valid) begin
        acc_cyc = cyc;
        m_frame = {SPI_WRITE_BIT, bus.req_addr, bus.req_data};
      end
    end
  end

  // Every-cycle comparison against the model
  logic e_ncs, e_sclk, e_busy, e_done, e_ready, e_copi, chk_copi;
  int   cmp_k, cmp_p;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("rst_ncs",   ncs,           1);
      check_output("rst_sclk",  sclk,          0);
      check_output("rst_copi",  copi,          0);
      check_output("rst_done",  bus.done,      0);
      check_output("rst_busy",  bus.busy,      0);
      check_output("rst_ready", bus.req_ready, 0);
    end else begin
      e_ncs = 1; e_sclk = 0; e_busy = 0; e_done = 0; e_ready = 0;
      e_copi = 0; chk_copi = 0;
      if (acc_cyc < 0) begin
        e_ready = (cyc >= 1);
      end else begin
        cmp_k = cyc - acc_cyc;
        if (cmp_k < LOW_LEN) begin
          e_ncs  = 0;
          e_busy = 1;
          if (cmp_k < CS_SETUP) begin
            chk_copi = 1;
            e_copi   = m_frame[15];
          end else if (cmp_k < SHIFT_END) begin
            cmp_p    = (cmp_k - CS_SETUP) / CLK_DIV;
            e_sclk   = cmp_p[0];
            chk_copi = 1;
            e_copi   = m_frame[15 - cmp_p / 2];
          end
        end else if (cmp_k < LOW_LEN + CS_GAP) begin
          e_busy = 1;
          e_done = (cmp_k == LOW_LEN);
        end else begin
          e_ready = 1;
        end
      end
      check_output("ncs",   ncs,           e_ncs);
      check_output("sclk",  sclk,          e_sclk);
      check_output("busy",  bus.busy,      e_busy);
      check_output("done",  bus.done,      e_done);
      check_output("ready", bus.req_ready, e_ready);
      if (chk_copi) check_output("copi", copi, e_copi);
    end
  end

  // Peripheral-side monitor: frame decode, register file, timing capture
  logic        prev_ncs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          mon_rises = 0;
  logic [15:0] cap = 16'h0;
  int          t_fall = 0, t_ncs_rise = -1, t_first_rise = -1, t_first_fall = -1, t_last_fall = 0;
  int          gap_last = -1;
  int          done_cnt = 0;
  int          reg_idx;
  logic [7:0]  regs [0:4];

  initial begin
    foreach (regs[i]) regs[i] = 8'h00;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ncs   = 1'b1;
      prev_sclk  = 1'b0;
      mon_rises  = 0;
      t_ncs_rise = -1;
    end else begin
      if (bus.done) done_cnt++;
      if (prev_ncs && !ncs) begin
        t_fall       = cyc;
        mon_rises    = 0;
        cap          = 16'h0;
        t_first_rise = -1;
        t_first_fall = -1;
        if (t_ncs_rise >= 0) gap_last = cyc - t_ncs_rise;
      end
      if (!prev_sclk && sclk) begin
        mon_rises++;
        cap = {cap[14:0], copi};
        if (mon_rises == 1) t_first_rise = cyc;
      end
      if (prev_sclk && !sclk) begin
        t_last_fall = cyc;
        if (t_first_fall < 0) t_first_fall = cyc;
      end
      if (!prev_ncs && ncs) begin
        t_ncs_rise = cyc;
        reg_idx    = int'(cap[14:8]);
        if (mon_rises == 16 && cap[15] == SPI_WRITE_BIT && reg_idx <= 4)
          regs[reg_idx] = cap[7:0];
      end
      prev_ncs  = ncs;
      prev_sclk = sclk;
    end
  end

  task automatic wait_accept(input string name);
    bit seen;
    bit got = 0;
    for (int i = 0; i < 1000; i++) begin
      seen = bus.req_ready;
      @(posedge clk);
      #2;
      if (seen) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("[TB] FAIL %s accept timeout actual=no_accept required=accept", name);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] a, input logic [7:0] d,
                                input bit change_after, input logic [7:0] d_alt);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    wait_accept("apply");
    bus.req_valid = 1'b0;
    if (change_after) bus.req_data = d_alt;
  endtask

  task automatic wait_done(input string name);
    int  start = done_cnt;
    bit  got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_cnt > start) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("[TB] FAIL %s done timeout actual=no_done required=done", name);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int done_before;
  bit hit5;

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 7'h00;
    bus.req_data  = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check_output("ready_before_edge", bus.req_ready, 0);
    @(posedge clk);
    #2 check_output("ready_after_edge", bus.req_ready, 1);

    $display("[TB] single write 0x04=0x80 with timing");
    done_before = done_cnt;
    apply_stimulus(PWM_DUTY, 8'h80, 1'b0, 8'h00);
    wait_done("w04");
    check_output("frame_bits",       cap, 16'h8480);
    check_output("sclk_rises",       mon_rises, 16);
    check_output("setup_to_rise",    t_first_rise - t_fall, 16);
    check_output("high_phase",       t_first_fall - t_first_rise, 8);
    check_output("last_fall_to_ncs", t_ncs_rise - t_last_fall, 8);
    check_output("ncs_low",          t_ncs_rise - t_fall, 272);
    repeat (CS_GAP + 4) @(negedge clk);
    check_output("done_pulses", done_cnt - done_before, 1);

    $display("[TB] loopback writes");
    apply_stimulus(EN_OUT_7_0,  8'hA5, 1'b0, 8'h00); wait_done("w00");
    apply_stimulus(EN_OUT_15_8, 8'h5A, 1'b0, 8'h00); wait_done("w01");
    apply_stimulus(EN_PWM_7_0,  8'hFF, 1'b0, 8'h00); wait_done("w02");
    apply_stimulus(EN_PWM_15_8, 8'h0F, 1'b0, 8'h00); wait_done("w03");
    check_output("reg00", regs[0], 8'hA5);
    check_output("reg01", regs[1], 8'h5A);
    check_output("reg02", regs[2], 8'hFF);
    check_output("reg03", regs[3], 8'h0F);
    check_output("reg04", regs[4], 8'h80);

    $display("[TB] back-to-back with req_valid held");
    bus.req_valid = 1'b1;
    bus.req_addr  = EN_OUT_7_0;
    bus.req_data  = 8'h11;
    wait_accept("b2b_first");
    bus.req_addr  = EN_OUT_15_8;
    bus.req_data  = 8'h22;
    wait_accept("b2b_second");
    bus.req_valid = 1'b0;
    wait_done("b2b");
    check_min("b2b_gap", gap_last, CS_GAP);
    check_output("b2b_reg00", regs[0], 8'h11);
    check_output("b2b_reg01", regs[1], 8'h22);

    $display("[TB] data changed after acceptance");
    apply_stimulus(EN_PWM_15_8, 8'h77, 1'b1, 8'h11);
    wait_done("latch");
    check_output("latched_data", regs[3], 8'h77);

    $display("[TB] reset after fifth sclk rise");
    done_before = done_cnt;
    apply_stimulus(EN_PWM_7_0, 8'h99, 1'b0, 8'h00);
    hit5 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!ncs && mon_rises == 5) begin
        hit5 = 1;
        break;
      end
    end
    if (!hit5) begin
      total++; bad++;
      $display("[TB] FAIL rise5 timeout actual=no_rise5 required=rise5");
    end
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_ncs",  ncs,  1);
    check_output("abort_sclk", sclk, 0);
    check_output("abort_copi", copi, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_output("abort_no_done", done_cnt - done_before, 0);
    check_output("abort_discard", regs[2], 8'hFF);
    apply_stimulus(EN_PWM_7_0, 8'h3C, 1'b0, 8'h00);
    wait_done("after_abort");
    check_output("after_abort_reg02", regs[2], 8'h3C);
    repeat (CS_GAP + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
